// File: rtl/adder64_sched_pkg.sv
// Shared types and constants for the 64-bit adder scheduler.
// Optional subtract support is enabled with `define ADDER64_SCHED_SUB_EN.
package adder64_sched_pkg;

    localparam int ADDER64_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_e;

endpackage

// File: rtl/adder64_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module adder64_rr_arb
    import adder64_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant,
    output logic               any_valid
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!any_valid && req[IDW'(idx)]) begin
                grant     = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder64_sched.sv
// Round-robin scheduler sharing one external 64-bit adder among NUM_REQ requesters.
// Define ADDER64_SCHED_SUB_EN to honour req_sub (op1 - op2 via ~op2 and cin=1).
module adder64_sched
    import adder64_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][ADDER64_W-1:0]  req_op1,
    input  logic [NUM_REQ-1:0][ADDER64_W-1:0]  req_op2,
    input  logic [NUM_REQ-1:0]                 req_cin,
    input  logic [NUM_REQ-1:0]                 req_sub,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [ADDER64_W-1:0]               rsp_result,
    output logic                               rsp_cout,
    output logic [ADDER64_W-1:0]               add_op1,
    output logic [ADDER64_W-1:0]               add_op2,
    output logic                               add_cin,
    input  logic [ADDER64_W-1:0]               add_result,
    input  logic                               add_cout,
    output logic                               busy,
    output logic [IDW-1:0]                     owner
);

    sched_state_e         state;
    sched_state_e         state_nxt;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       grant;
    logic                 any_valid;
    logic                 accept;
    logic [ADDER64_W-1:0] op2_sel;
    logic                 cin_sel;

    adder64_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign accept = (state == IDLE) && any_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready[owner]) state_nxt = RESP == RESP ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rst so every output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state != IDLE);
        if (accept && !rst) req_ready[grant] = 1'b1;
        if (state == RESP) rsp_valid[owner] = 1'b1;
    end

    always_comb begin
        op2_sel = req_op2[grant];
        cin_sel = req_cin[grant];
`ifdef ADDER64_SCHED_SUB_EN
        if (req_sub[grant]) begin
            op2_sel = ~req_op2[grant];
            cin_sel = 1'b1;
        end
`endif
    end

`ifndef ADDER64_SCHED_SUB_EN
    logic unused_sub;
    assign unused_sub = ^req_sub;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            owner      <= '0;
            add_op1    <= '0;
            add_op2    <= '0;
            add_cin    <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            if (accept) begin
                add_op1 <= req_op1[grant];
                add_op2 <= op2_sel;
                add_cin <= cin_sel;
                owner   <= grant;
                ptr     <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (state == EXEC) begin
                rsp_result <= add_result;
                rsp_cout   <= add_cout;
            end
        end
    end

endmodule

// File: tb/tb_adder64_sched.sv
// Self-checking bench for adder64_sched with a protocol-level reference model.
module tb_adder64_sched;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][63:0]   req_op1;
    logic [N-1:0][63:0]   req_op2;
    logic [N-1:0]         req_cin;
    logic [N-1:0]         req_sub;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic [63:0]          rsp_result;
    logic                 rsp_cout;
    logic [63:0]          add_op1;
    logic [63:0]          add_op2;
    logic                 add_cin;
    logic [63:0]          add_result;
    logic                 add_cout;
    logic                 busy;
    logic [1:0]           owner;

    always #5 clk = ~clk;

    adder64_sched #(
        .NUM_REQ (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_cin    (req_cin),
        .req_sub    (req_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .add_op1    (add_op1),
        .add_op2    (add_op2),
        .add_cin    (add_cin),
        .add_result (add_result),
        .add_cout   (add_cout),
        .busy       (busy),
        .owner      (owner)
    );

    // External adder
    assign {add_cout, add_result} = {1'b0, add_op1} + {1'b0, add_op2} + {64'd0, add_cin};

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m_phase;   // 0 idle, 1 exec, 2 resp
    int          m_ptr;
    int          m_owner;
    logic [63:0] m_op1, m_op2, m_res;
    logic        m_cin, m_cout;
    logic [64:0] m_sum;
    int          obs_g[$];
    int          obs_c[$];

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit sub_active(input logic sub);
        bit s;
        s = 1'b0;
`ifdef ADDER64_SCHED_SUB_EN
        s = sub;
`endif
        return s && (sub === 1'b1);
    endfunction

    // Result as plain arithmetic: sum with carry, or difference with no-borrow flag.
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
        logic [64:0] r;
        if (sub_active(sub)) begin
            r[63:0] = a - b;
            r[64]   = (a >= b);
        end else begin
            r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        end
        return r;
    endfunction

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        m_phase = 0; m_ptr = 0; m_owner = 0;
        m_op1 = '0; m_op2 = '0; m_cin = 1'b0; m_res = '0; m_cout = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_result"}, rsp_result, 0);
        chk({tag, "_rsp_cout"}, rsp_cout, 0);
        chk({tag, "_add_op1"}, add_op1, 0);
        chk({tag, "_add_op2"}, add_op2, 0);
        chk({tag, "_add_cin"}, add_cin, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
    endtask

    // Called at edge+1 with inputs driven; checks outputs, advances model over one edge.
    task automatic step();
        logic [N-1:0] er, ev;
        int g;
        #1;
        g  = rr(req_valid, m_ptr);
        er = '0;
        ev = '0;
        if (m_phase == 0 && g >= 0) er[g] = 1'b1;
        if (m_phase == 2) ev[m_owner] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, ev);
        chk("busy", busy, m_phase != 0);
        chk("owner", owner, m_owner);
        chk("add_op1", add_op1, m_op1);
        chk("add_op2", add_op2, m_op2);
        chk("add_cin", add_cin, m_cin);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_cout", rsp_cout, m_cout);
        if (req_ready != 0) begin
            for (int k = 0; k < N; k++) if (req_ready[k]) obs_g.push_back(k);
            obs_c.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        case (m_phase)
            0: if (g >= 0) begin
                m_owner = g;
                m_ptr   = (g + 1) % N;
                m_op1   = req_op1[g];
                m_op2   = sub_active(req_sub[g]) ? ~req_op2[g] : req_op2[g];
                m_cin   = sub_active(req_sub[g]) ? 1'b1 : req_cin[g];
                m_sum   = ref_sum(req_op1[g], req_op2[g], req_cin[g], req_sub[g]);
                m_phase = 1;
            end
            1: begin
                {m_cout, m_res} = m_sum;
                m_phase = 2;
            end
            default: if (rsp_ready[m_owner]) m_phase = 0;
        endcase
        #1;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            req_op1[k] = ($urandom_range(0, 5) == 0) ? '1 : {$urandom, $urandom};
            req_op2[k] = ($urandom_range(0, 5) == 0) ? 64'd1 : {$urandom, $urandom};
            req_cin[k] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_op1 = '0; req_op2 = '0; req_cin = '0; req_sub = '0;
        rsp_ready = '0;
        reset_model();
        #2;
        check_all_zero("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        step();

        // Single add: all-ones + 1 from requester 1
        req_valid = 4'b0010;
        req_op1[1] = '1; req_op2[1] = 64'd1; req_cin[1] = 1'b0;
        step();
        req_valid = '0;
        step();
        step();
        chk("single_result", rsp_result, 64'd0);
        chk("single_cout", rsp_cout, 1'b1);
        chk("single_valid", rsp_valid, 4'b0010);
        rsp_ready = 4'b0010;
        step();
        chk("single_idle", busy, 1'b0);
        rsp_ready = '0;

        // 5 - 7 from requester 0 with sub set
        req_valid = 4'b0001;
        req_op1[0] = 64'd5; req_op2[0] = 64'd7; req_cin[0] = 1'b0; req_sub[0] = 1'b1;
        step();
        req_valid = '0;
        step();
        step();
`ifdef ADDER64_SCHED_SUB_EN
        chk("sub_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        chk("sub_result", rsp_result, 64'd12);
`endif
        chk("sub_cout", rsp_cout, 1'b0);
        rsp_ready = '1;
        step();
        req_sub = '0;

        // All requesters held valid after reset: expect 0,1,2,3,0 at 3-cycle spacing
        rst = 1'b1;
        reset_model();
        @(posedge clk);
        #1 rst = 1'b0;
        rand_ops();
        req_valid = '1;
        rsp_ready = '1;
        obs_g.delete();
        obs_c.delete();
        for (int i = 0; i < 40 && obs_g.size() < 5; i++) step();
        chk("rr_count", obs_g.size(), 5);
        for (int i = 0; i < obs_g.size() && i < 5; i++) begin
            chk($sformatf("rr_grant%0d", i), obs_g[i], i % N);
            if (i > 0) chk($sformatf("rr_spacing%0d", i), obs_c[i] - obs_c[i-1], 3);
        end
        req_valid = '0;
        repeat (3) step();

        // Back-pressure on requester 2
        rsp_ready = '0;
        rand_ops();
        req_valid = 4'b0100;
        step();
        req_valid = '1;
        step();
        repeat (5) step();
        chk("bp_busy", busy, 1'b1);
        chk("bp_ready", req_ready, 4'b0000);
        req_valid = '0;
        rsp_ready = 4'b0100;
        step();
        chk("bp_resume", busy, 1'b0);

        // Owner 3 in RESP with only non-owner rsp_ready bits high
        rsp_ready = 4'b0111;
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        repeat (4) step();
        chk("nonowner_hold", rsp_valid, 4'b1000);
        rsp_ready = 4'b1000;
        step();
        chk("nonowner_release", busy, 1'b0);

        // Asynchronous reset during RESP (ptr is 3 beforehand)
        rsp_ready = '0;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        step();
        chk("pre_rst_resp", rsp_valid, 4'b0100);
        req_valid = 4'b1001;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        reset_model();
        @(posedge clk);
        #1 rst = 1'b0;
        obs_g.delete();
        obs_c.delete();
        step();
        chk("post_rst_grants", obs_g.size(), 1);
        if (obs_g.size() > 0) chk("post_rst_grant", obs_g[0], 0);
        req_valid = '0;
        rsp_ready = '1;
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req_sub   = N'($urandom);
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            step();
        end
        req_valid = '0;
        rsp_ready = '1;
        repeat (4) step();
        chk("final_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
